// File: rtl/tape_out_shaper_pkg.sv
// Shared definitions for the tape-out audio path: FSM states, default
// constants, 16-bit saturation limits and the slew-limiting helper.
package tape_out_shaper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_FADE
  } state_t;

  localparam logic [15:0] DEF_AMPL         = 16'd12000;
  localparam logic [15:0] DEF_RAMP_STEP    = 16'd3000;
  localparam logic [15:0] DEF_FADE_STEP    = 16'd500;
  localparam logic [15:0] DEF_IDLE_SAMPLES = 16'd4800;

  localparam logic signed [15:0] SAT16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT16_MIN = 16'sh8000;

  // Move cur toward tgt by at most step; lands exactly on tgt when within reach.
  function automatic logic signed [16:0] slew17(input logic signed [16:0] cur,
                                                input logic signed [16:0] tgt,
                                                input logic [15:0]        step);
    logic signed [17:0] diff;
    logic signed [17:0] stp;
    diff = {tgt[16], tgt} - {cur[16], cur};
    stp  = {2'b00, step};
    if ((diff <= stp) && (diff >= -stp)) begin
      slew17 = tgt;
    end else if (diff > 18'sd0) begin
      slew17 = cur + stp[16:0];
    end else begin
      slew17 = cur - stp[16:0];
    end
  endfunction

endpackage

// File: rtl/tape_out_shaper_sat_add16.sv
// Combinational 16+16 -> 16 saturating two's-complement adder.
module sat_add16
  import tape_out_shaper_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [16:0] sum;

  always_comb begin
    sum = {a[15], a} + {b[15], b};
    // Bits 16 and 15 disagree only when the true sum leaves the 16-bit range.
    if (sum[16] != sum[15]) begin
      y = sum[16] ? SAT16_MIN : SAT16_MAX;
    end else begin
      y = sum[15:0];
    end
  end

endmodule

// File: rtl/tape_out_shaper.sv
// Tape-out level to slew-limited, idle-fading audio sample, mixed with the
// sound sample and emitted once per LRCK period.
module tape_out_shaper
  import tape_out_shaper_pkg::*;
#(
  parameter logic [15:0] AMPL         = DEF_AMPL,
  parameter logic [15:0] RAMP_STEP    = DEF_RAMP_STEP,
  parameter logic [15:0] FADE_STEP    = DEF_FADE_STEP,
  parameter logic [15:0] IDLE_SAMPLES = DEF_IDLE_SAMPLES
) (
  input  logic        clk18,
  input  logic        reset_n,
  input  logic        tapeout,
  input  logic        lrck,
  input  logic [15:0] pulse_sample,
  output logic [15:0] sample_out,
  output logic        sample_stb,
  output logic        active
);

  logic               tape_s1_q, tape_s_q;
  logic               lrck_r1_q, lrck_r2_q;
  logic               tick, tick_q, stb_q;
  logic               tape_edge;
  logic               last_bit_q, last_bit_d;
  state_t             state_q, state_d;
  logic signed [16:0] level_q, level_d;
  logic signed [16:0] tgt, ramp_lvl, fade_lvl;
  logic [15:0]        idle_cnt_q, idle_cnt_d;
  logic [15:0]        sample_out_q, sample_out_d;
  logic [15:0]        mix;

  sat_add16 u_mix (
    .a (pulse_sample),
    .b (level_q[15:0]),
    .y (mix)
  );

  always_comb begin
    tick      = lrck_r1_q & ~lrck_r2_q;
    tape_edge = tick & (tape_s_q ^ last_bit_q);
    tgt       = tape_s_q ? $signed({1'b0, AMPL}) : -$signed({1'b0, AMPL});
    ramp_lvl  = slew17(level_q, tgt, RAMP_STEP);
    fade_lvl  = slew17(level_q, 17'sd0, FADE_STEP);

    last_bit_d   = last_bit_q;
    state_d      = state_q;
    level_d      = level_q;
    idle_cnt_d   = idle_cnt_q;
    sample_out_d = tick_q ? mix : sample_out_q;

    if (tick) begin
      last_bit_d = tape_s_q;
      if (tape_edge) begin
        idle_cnt_d = '0;
      end else if (((state_q == ST_RAMP) || (state_q == ST_HOLD)) && (idle_cnt_q != '1)) begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end

      // An edge from any state slews from the current level, so it also wins
      // over the idle-limit fade and never resets an in-flight ramp.
      if (tape_edge || (state_q == ST_RAMP)) begin
        level_d = ramp_lvl;
        state_d = (ramp_lvl == tgt) ? ST_HOLD : ST_RAMP;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (idle_cnt_q >= IDLE_SAMPLES) state_d = ST_FADE;
          end
          ST_FADE: begin
            level_d = fade_lvl;
            if (fade_lvl == 17'sd0) state_d = ST_IDLE;
          end
          default: level_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      tape_s1_q    <= 1'b0;
      tape_s_q     <= 1'b0;
      lrck_r1_q    <= 1'b0;
      lrck_r2_q    <= 1'b0;
      tick_q       <= 1'b0;
      stb_q        <= 1'b0;
      last_bit_q   <= 1'b0;
      state_q      <= ST_IDLE;
      level_q      <= '0;
      idle_cnt_q   <= '0;
      sample_out_q <= '0;
    end else begin
      tape_s1_q    <= tapeout;
      tape_s_q     <= tape_s1_q;
      lrck_r1_q    <= lrck;
      lrck_r2_q    <= lrck_r1_q;
      tick_q       <= tick;
      stb_q        <= tick_q;
      last_bit_q   <= last_bit_d;
      state_q      <= state_d;
      level_q      <= level_d;
      idle_cnt_q   <= idle_cnt_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign sample_stb = stb_q;
  assign active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tape_out_shaper.sv
// Self-checking bench for tape_out_shaper against a per-sample behavioural model.
module tb_tape_out_shaper;

  localparam int A     = 12000;
  localparam int RS    = 3000;
  localparam int FS    = 500;
  localparam int IDLEN = 4800;

  logic        clk18 = 1'b0;
  logic        reset_n = 1'b0;
  logic        tapeout = 1'b0;
  logic        lrck = 1'b0;
  logic        lrck_run = 1'b1;
  logic [15:0] pulse_sample = '0;
  logic [15:0] sample_out;
  logic        sample_stb;
  logic        active;

  int n_assert = 0;
  int n_fail   = 0;

  tape_out_shaper #(
    .AMPL         (16'd12000),
    .RAMP_STEP    (16'd3000),
    .FADE_STEP    (16'd500),
    .IDLE_SAMPLES (16'd4800)
  ) dut (
    .clk18        (clk18),
    .reset_n      (reset_n),
    .tapeout      (tapeout),
    .lrck         (lrck),
    .pulse_sample (pulse_sample),
    .sample_out   (sample_out),
    .sample_stb   (sample_stb),
    .active       (active)
  );

  always #5 clk18 = ~clk18;

  // LRCK with a 6-cycle period so the long idle scenarios stay short.
  int lrck_div = 0;
  always @(posedge clk18) begin
    if (lrck_run) begin
      if (lrck_div == 2) begin
        lrck_div <= 0;
        lrck     <= ~lrck;
      end else begin
        lrck_div <= lrck_div + 1;
      end
    end
  end

  // Behavioural model: phase 0 silent, 1 slewing to plateau, 2 on plateau, 3 fading.
  int m_level, m_since, m_phase;
  bit m_last;

  function automatic int approach(input int cur, input int tgt, input int step);
    int d;
    d = tgt - cur;
    if (d <= step && d >= -step) return tgt;
    return (d > 0) ? cur + step : cur - step;
  endfunction

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  task automatic model_reset();
    m_level = 0; m_since = 0; m_phase = 0; m_last = 1'b0;
  endtask

  task automatic model_tick(input bit t);
    int  plateau;
    int  quiet;
    bit  e;
    plateau = t ? A : -A;
    e       = (t != m_last);
    quiet   = m_since;
    m_last  = t;
    if (e) m_since = 0;
    else if ((m_phase == 1 || m_phase == 2) && m_since < 65535) m_since++;
    if (e || m_phase == 1) begin
      m_level = approach(m_level, plateau, RS);
      m_phase = (m_level == plateau) ? 2 : 1;
    end else if (m_phase == 2 && quiet >= IDLEN) begin
      m_phase = 3;
    end else if (m_phase == 3) begin
      m_level = approach(m_level, 0, FS);
      if (m_level == 0) m_phase = 0;
    end
  endtask

  task automatic wait_stb(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk18);
      cyc++;
    end while (sample_stb !== 1'b1 && cyc < 64);
    n_assert++;
    if (sample_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL stb_timeout: sample_stb=%b after %0d cycles, required 1", sample_stb, cyc);
    end
  endtask

  // Drive one sample period; returns observed and model-expected outputs.
  task automatic tick_step(input bit t, input logic [15:0] p,
                           output logic [15:0] got, output logic [15:0] exp,
                           output logic got_act, output logic exp_act, output int cyc);
    tapeout      = t;
    pulse_sample = p;
    wait_stb(cyc);
    model_tick(t);
    got     = sample_out;
    got_act = active;
    exp     = sat16($signed(p) + m_level);
    exp_act = (m_phase != 0);
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc;
    repeat (20) @(negedge clk18);
    n_assert += 3;
    if (sample_out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h want 0000", sample_out); end
    if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", sample_stb); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    @(posedge lrck);
    #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      tick_step(1'b0, 16'h0000, got, exp, ga, ea, cyc);
      n_assert += 2;
      if (got !== 16'h0000) begin n_fail++; $display("FAIL quiet_out[%0d]: got %h want 0000", i, got); end
      if (ga !== 1'b0) begin n_fail++; $display("FAIL quiet_active[%0d]: got %b want 0", i, ga); end
      if (i > 0) begin
        n_assert++;
        if (cyc != 6) begin n_fail++; $display("FAIL stb_period[%0d]: got %0d want 6", i, cyc); end
      end
    end
  endtask

  task automatic test_ramp_up();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc;
    int want[6] = '{3000, 6000, 9000, 12000, 12000, 12000};
    for (int i = 0; i < 6; i++) begin
      tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
      n_assert += 3;
      if (got !== exp) begin n_fail++; $display("FAIL ramp_up_model[%0d]: got %0d want %0d", i, $signed(got), $signed(exp)); end
      if ($signed(got) != want[i]) begin n_fail++; $display("FAIL ramp_up_const[%0d]: got %0d want %0d", i, $signed(got), want[i]); end
      if (ga !== 1'b1) begin n_fail++; $display("FAIL ramp_up_active[%0d]: got %b want 1", i, ga); end
    end
  endtask

  task automatic test_ramp_down_toggle();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc;
    int tog[3] = '{9000, 6000, 9000};
    for (int i = 0; i < 9; i++) begin
      tick_step(1'b0, 16'h0000, got, exp, ga, ea, cyc);
      n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL ramp_down[%0d]: got %0d want %0d", i, $signed(got), $signed(exp)); end
      if (i == 7) begin
        n_assert++;
        if ($signed(got) != -12000) begin n_fail++; $display("FAIL ramp_down_end: got %0d want -12000", $signed(got)); end
      end
    end
    for (int i = 0; i < 8; i++) tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
    n_assert++;
    if (got !== exp) begin n_fail++; $display("FAIL reramp_top: got %0d want %0d", $signed(got), $signed(exp)); end
    for (int i = 0; i < 3; i++) begin
      tick_step((i == 2) ? 1'b1 : 1'b0, 16'h0000, got, exp, ga, ea, cyc);
      n_assert += 2;
      if (got !== exp) begin n_fail++; $display("FAIL toggle_model[%0d]: got %0d want %0d", i, $signed(got), $signed(exp)); end
      if ($signed(got) != tog[i]) begin n_fail++; $display("FAIL toggle_const[%0d]: got %0d want %0d", i, $signed(got), tog[i]); end
    end
    for (int i = 0; i < 2; i++) tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
  endtask

  task automatic test_saturation();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc;
    tick_step(1'b1, 16'h7000, got, exp, ga, ea, cyc);
    n_assert += 2;
    if (got !== exp) begin n_fail++; $display("FAIL sat_pos_model: got %h want %h", got, exp); end
    if (got !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fff", got); end
    for (int i = 0; i < 8; i++) tick_step(1'b0, 16'h9000, got, exp, ga, ea, cyc);
    n_assert += 2;
    if (got !== exp) begin n_fail++; $display("FAIL sat_neg_model: got %h want %h", got, exp); end
    if (got !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", got); end
  endtask

  task automatic test_lrck_stopped();
    logic [15:0] got, exp, held;
    logic ga, ea;
    int cyc, stbs;
    tick_step(1'b0, 16'h0000, got, exp, ga, ea, cyc);
    held     = sample_out;
    lrck_run = 1'b0;
    tapeout  = 1'b1;
    stbs     = 0;
    repeat (60) begin
      @(negedge clk18);
      if (sample_stb === 1'b1) stbs++;
    end
    n_assert += 3;
    if (stbs != 0) begin n_fail++; $display("FAIL stopped_stb: got %0d strobes want 0", stbs); end
    if (sample_out !== held) begin n_fail++; $display("FAIL stopped_out: got %h want %h", sample_out, held); end
    if (active !== 1'b1) begin n_fail++; $display("FAIL stopped_active: got %b want 1", active); end
    lrck_run = 1'b1;
    tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
    n_assert += 2;
    if (got !== exp) begin n_fail++; $display("FAIL resume_model: got %0d want %0d", $signed(got), $signed(exp)); end
    if ($signed(got) != -9000) begin n_fail++; $display("FAIL resume_const: got %0d want -9000", $signed(got)); end
  endtask

  task automatic test_fade();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc, steps, fade_ticks;
    steps = 0;
    while (m_phase != 3 && steps < 6000) begin
      tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
      steps++;
      n_assert += 2;
      if (got !== exp) begin n_fail++; $display("FAIL hold_out[%0d]: got %0d want %0d", steps, $signed(got), $signed(exp)); end
      if (ga !== ea) begin n_fail++; $display("FAIL hold_active[%0d]: got %b want %b", steps, ga, ea); end
    end
    fade_ticks = 0;
    ga = 1'b1;
    while (ga === 1'b1 && fade_ticks < 40) begin
      tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
      fade_ticks++;
      n_assert += 2;
      if (got !== exp) begin n_fail++; $display("FAIL fade_out[%0d]: got %0d want %0d", fade_ticks, $signed(got), $signed(exp)); end
      if (ga !== ea) begin n_fail++; $display("FAIL fade_active[%0d]: got %b want %b", fade_ticks, ga, ea); end
    end
    n_assert += 2;
    if (fade_ticks != 24) begin n_fail++; $display("FAIL fade_len: got %0d ticks want 24", fade_ticks); end
    if (got !== 16'h0000) begin n_fail++; $display("FAIL fade_end: got %h want 0000", got); end
    tick_step(1'b1, 16'h0100, got, exp, ga, ea, cyc);
    n_assert += 2;
    if (got !== 16'h0100) begin n_fail++; $display("FAIL mix_zero: got %h want 0100", got); end
    if (ga !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b want 0", ga); end
  endtask

  task automatic test_fade_edge();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc, steps;
    steps = 0;
    while (m_phase != 3 && steps < 6000) begin
      tick_step(1'b0, 16'h0000, got, exp, ga, ea, cyc);
      steps++;
      n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL neg_hold[%0d]: got %0d want %0d", steps, $signed(got), $signed(exp)); end
    end
    for (int i = 0; i < 10; i++) begin
      tick_step(1'b0, 16'h0000, got, exp, ga, ea, cyc);
      n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL fade10[%0d]: got %0d want %0d", i, $signed(got), $signed(exp)); end
    end
    n_assert++;
    if ($signed(got) != -7000) begin n_fail++; $display("FAIL fade10_level: got %0d want -7000", $signed(got)); end
    tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
    n_assert += 3;
    if (got !== exp) begin n_fail++; $display("FAIL fade_edge_model: got %0d want %0d", $signed(got), $signed(exp)); end
    if ($signed(got) != -4000) begin n_fail++; $display("FAIL fade_edge_const: got %0d want -4000", $signed(got)); end
    if (ga !== 1'b1) begin n_fail++; $display("FAIL fade_edge_active: got %b want 1", ga); end
  endtask

  task automatic test_reset_mid_ramp();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc, stbs;
    tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
    #2 reset_n = 1'b0;
    #1;
    n_assert += 2;
    if (sample_out !== 16'h0000) begin n_fail++; $display("FAIL async_rst_out: got %h want 0000", sample_out); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL async_rst_active: got %b want 0", active); end
    stbs = 0;
    repeat (12) begin
      @(negedge clk18);
      if (sample_stb === 1'b1) stbs++;
    end
    n_assert++;
    if (stbs != 0) begin n_fail++; $display("FAIL rst_stb: got %0d strobes want 0", stbs); end
    @(posedge lrck);
    #1 reset_n = 1'b1;
    model_reset();
    // First tick after release still sees the cleared synchronizer.
    wait_stb(cyc);
    model_tick(1'b0);
    n_assert++;
    if (sample_out !== sat16(m_level)) begin n_fail++; $display("FAIL rel_first: got %h want %h", sample_out, sat16(m_level)); end
    tick_step(1'b1, 16'h0000, got, exp, ga, ea, cyc);
    n_assert += 3;
    if (got !== exp) begin n_fail++; $display("FAIL rel_second_model: got %0d want %0d", $signed(got), $signed(exp)); end
    if ($signed(got) != 3000) begin n_fail++; $display("FAIL rel_second_const: got %0d want 3000", $signed(got)); end
    if (ga !== 1'b1) begin n_fail++; $display("FAIL rel_active: got %b want 1", ga); end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic ga, ea;
    int cyc;
    bit t;
    t = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) t = ~t;
      tick_step(t, 16'($urandom), got, exp, ga, ea, cyc);
      n_assert += 2;
      if (got !== exp) begin n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", i, got, exp); end
      if (ga !== ea) begin n_fail++; $display("FAIL rand_active[%0d]: got %b want %b", i, ga, ea); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_toggle();
    test_saturation();
    test_lrck_stopped();
    test_fade();
    test_fade_edge();
    test_reset_mid_ramp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
